// File: rtl/avr_hvpp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : avr_hvpp_pkg
//  Description : Shared constants and types for the AVR high-voltage parallel
//                programming responder. These are the programming command
//                bytes, the XA1/XA0 action encoding and the responder states.
//  Revision    : 1.0 - initial release
// ============================================================================
package avr_hvpp_pkg;

    // Command bytes latched by an XTAL "load command" action
    localparam logic [7:0] CMD_WRITE_FLASH = 8'h10;
    localparam logic [7:0] CMD_READ_FLASH  = 8'h02;
    localparam logic [7:0] CMD_READ_SIG    = 8'h08;
    localparam logic [7:0] CMD_WRITE_FUSE  = 8'h40;
    localparam logic [7:0] CMD_READ_FUSE   = 8'h04;
    localparam logic [7:0] CMD_CHIP_ERASE  = 8'h80;

    // {XA1, XA0} action selected on an XTAL rising edge
    typedef enum logic [1:0] {
        XA_LOAD_ADDR = 2'b00,
        XA_LOAD_DATA = 2'b01,
        XA_LOAD_CMD  = 2'b10,
        XA_NOP       = 2'b11
    } xa_action_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ERASE = 2'd2
    } state_e;

endpackage : avr_hvpp_pkg
`default_nettype wire

// File: rtl/hvpp_pin_sync.sv
`default_nettype none
// ============================================================================
//  Module      : hvpp_pin_sync
//  Description : Two-flop synchroniser for the programming pins (controls and
//                data, kept together so they stay cycle-aligned) plus rising
//                edge detect on XTAL and falling edge detect on WR_n.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                *_i                  - raw pin inputs
//                xa_o, bs1_o, oe_n_o,
//                data_o               - synchronised levels
//                xtal_rise_o          - one-cycle pulse on synchronised XTAL rise
//                wr_fall_o            - one-cycle pulse on synchronised WR_n fall
//  Revision    : 1.0 - initial release
// ============================================================================
module hvpp_pin_sync
    import avr_hvpp_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       xtal_i,
    input  logic       xa0_i,
    input  logic       xa1_bs2_i,
    input  logic       pagel_bs1_i,
    input  logic       wr_n_i,
    input  logic       oe_n_i,
    input  logic [7:0] data_i,
    output xa_action_e xa_o,
    output logic       bs1_o,
    output logic       oe_n_o,
    output logic [7:0] data_o,
    output logic       xtal_rise_o,
    output logic       wr_fall_o
);

    // Bit layout: [0]=xtal [1]=xa0 [2]=xa1 [3]=bs1 [4]=wr_n [5]=oe_n [13:6]=data
    localparam int         W       = 14;
    // Active-low strobes idle high so release from reset creates no false edge
    localparam logic [W-1:0] C_RST_VAL = 14'b00000000_110000;

    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;
    logic         xtal_prev_q;
    logic         wr_n_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q      <= C_RST_VAL;
            sync_q      <= C_RST_VAL;
            xtal_prev_q <= 1'b0;
            wr_n_prev_q <= 1'b1;
        end else begin
            meta_q      <= {data_i, oe_n_i, wr_n_i, pagel_bs1_i, xa1_bs2_i, xa0_i, xtal_i};
            sync_q      <= meta_q;
            xtal_prev_q <= sync_q[0];
            wr_n_prev_q <= sync_q[4];
        end
    end

    assign xa_o        = xa_action_e'(sync_q[2:1]);
    assign bs1_o       = sync_q[3];
    assign oe_n_o      = sync_q[5];
    assign data_o      = sync_q[13:6];
    assign xtal_rise_o = sync_q[0] & ~xtal_prev_q;
    assign wr_fall_o   = ~sync_q[4] & wr_n_prev_q;

endmodule : hvpp_pin_sync
`default_nettype wire

// File: rtl/avr_hvpp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : avr_hvpp_responder
//  Description : Device-side model of the AVR high-voltage parallel
//                programming interface. Latches address/data/command on XTAL,
//                runs flash/fuse writes and chip erase on WR, answers OE reads.
//  Ports       : clk, rst_n   - clock, async active-low reset
//                xtal, xa0, xa1_bs2, pagel_bs1, wr_n, oe_n, data_in
//                             - programming pins driven by the programmer
//                data_out     - read data (registered)
//                data_oe      - data pin drive enable (registered)
//                rdy          - RDY/BSY, 1 = ready
//  Revision    : 1.0 - initial release
// ============================================================================
module avr_hvpp_responder
    import avr_hvpp_pkg::*;
#(
    parameter int         AW           = 6,     // 2..16
    parameter int         PROG_CYCLES  = 16,
    parameter logic [7:0] SIG0         = 8'h1E,
    parameter logic [7:0] SIG1         = 8'h91,
    parameter logic [7:0] SIG2         = 8'h09,
    parameter logic [7:0] FUSE_LO_INIT = 8'hE1,
    parameter logic [7:0] FUSE_HI_INIT = 8'hF7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       xtal,
    input  logic       xa0,
    input  logic       xa1_bs2,
    input  logic       pagel_bs1,
    input  logic       wr_n,
    input  logic       oe_n,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       rdy
);

    localparam int CW = $clog2(PROG_CYCLES + 1);

    xa_action_e    w_xa;
    logic          w_bs1, w_oe_n, w_xtal_rise, w_wr_fall;
    logic [7:0]    w_din;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] eidx_q, eidx_d;
    logic [7:0]    cmd_q, cmd_d, dlo_q, dlo_d, dhi_q, dhi_d;
    logic [7:0]    fuse_lo_q, fuse_lo_d, fuse_hi_q, fuse_hi_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [15:0]   w_addr_ext;
    logic          data_oe_q;
    logic [7:0]    data_out_q, w_rd;
    logic          w_idle, w_wr_go, w_xtal_go;
    logic          w_mem_we;
    logic [AW-1:0] w_mem_addr;
    logic [15:0]   w_mem_wdata;
    logic [15:0]   mem_q [2**AW];

    hvpp_pin_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .xtal_i      (xtal),
        .xa0_i       (xa0),
        .xa1_bs2_i   (xa1_bs2),
        .pagel_bs1_i (pagel_bs1),
        .wr_n_i      (wr_n),
        .oe_n_i      (oe_n),
        .data_i      (data_in),
        .xa_o        (w_xa),
        .bs1_o       (w_bs1),
        .oe_n_o      (w_oe_n),
        .data_o      (w_din),
        .xtal_rise_o (w_xtal_rise),
        .wr_fall_o   (w_wr_fall)
    );

    assign w_idle  = (state_q == IDLE);
    assign w_wr_go = w_idle & w_wr_fall;
    // WR wins a same-cycle collision; data pins are never sampled while driven
    assign w_xtal_go = w_idle & w_xtal_rise & ~w_wr_fall & w_oe_n & ~data_oe_q;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            eidx_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            eidx_q  <= eidx_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        eidx_d  = eidx_q;
        unique case (state_q)
            IDLE: begin
                if (w_wr_fall) begin
                    if (cmd_q == CMD_WRITE_FLASH || cmd_q == CMD_WRITE_FUSE) begin
                        state_d = BUSY;
                        cnt_d   = CW'(PROG_CYCLES - 1);
                    end else if (cmd_q == CMD_CHIP_ERASE) begin
                        state_d = ERASE;
                        eidx_d  = '0;
                    end
                end
            end
            BUSY: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            ERASE: begin
                eidx_d = eidx_q + 1'b1;
                if (eidx_q == {AW{1'b1}}) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        rdy         = w_idle;
        w_mem_we    = 1'b0;
        w_mem_addr  = addr_q;
        w_mem_wdata = {dhi_q, dlo_q};
        if (state_q == ERASE) begin
            w_mem_we    = 1'b1;
            w_mem_addr  = eidx_q;
            w_mem_wdata = 16'hFFFF;
        end else if (w_wr_go && cmd_q == CMD_WRITE_FLASH) begin
            w_mem_we = 1'b1;
        end
    end

    // Flash array is deliberately left out of reset
    always_ff @(posedge clk) begin
        if (w_mem_we) mem_q[w_mem_addr] <= w_mem_wdata;
    end

    // ---------------- Command/address/data latches ----------------
    always_comb begin
        cmd_d      = cmd_q;
        addr_d     = addr_q;
        dlo_d      = dlo_q;
        dhi_d      = dhi_q;
        fuse_lo_d  = fuse_lo_q;
        fuse_hi_d  = fuse_hi_q;
        w_addr_ext = 16'(addr_q);
        if (w_xtal_go) begin
            unique case (w_xa)
                XA_LOAD_ADDR: begin
                    // Assemble a 16-bit address, keep only the implemented bits
                    if (w_bs1) w_addr_ext[15:8] = w_din;
                    else       w_addr_ext[7:0]  = w_din;
                    addr_d = w_addr_ext[AW-1:0];
                end
                XA_LOAD_DATA: begin
                    if (w_bs1) dhi_d = w_din;
                    else       dlo_d = w_din;
                end
                XA_LOAD_CMD: cmd_d = w_din;
                XA_NOP:      ;
            endcase
        end
        if (w_wr_go && cmd_q == CMD_WRITE_FUSE) begin
            if (w_bs1) fuse_hi_d = dlo_q;
            else       fuse_lo_d = dlo_q;
        end
    end

    // ---------------- Read mux ----------------
    always_comb begin
        w_rd = 8'hFF;
        if (w_idle) begin
            case (cmd_q)
                CMD_READ_FLASH: w_rd = w_bs1 ? mem_q[addr_q][15:8] : mem_q[addr_q][7:0];
                CMD_READ_SIG: begin
                    case (addr_q[1:0])
                        2'd0:    w_rd = SIG0;
                        2'd1:    w_rd = SIG1;
                        2'd2:    w_rd = SIG2;
                        default: w_rd = 8'hFF;
                    endcase
                end
                CMD_READ_FUSE:  w_rd = w_bs1 ? fuse_hi_q : fuse_lo_q;
                default:        w_rd = 8'hFF;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_q      <= 8'h00;
            addr_q     <= '0;
            dlo_q      <= 8'hFF;
            dhi_q      <= 8'hFF;
            fuse_lo_q  <= FUSE_LO_INIT;
            fuse_hi_q  <= FUSE_HI_INIT;
            data_oe_q  <= 1'b0;
            data_out_q <= 8'hFF;
        end else begin
            cmd_q      <= cmd_d;
            addr_q     <= addr_d;
            dlo_q      <= dlo_d;
            dhi_q      <= dhi_d;
            fuse_lo_q  <= fuse_lo_d;
            fuse_hi_q  <= fuse_hi_d;
            data_oe_q  <= ~w_oe_n;
            data_out_q <= w_rd;
        end
    end

    assign data_out = data_out_q;
    assign data_oe  = data_oe_q;

endmodule : avr_hvpp_responder
`default_nettype wire

// File: tb/tb_avr_hvpp_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avr_hvpp_responder
//  Description : Self-checking bench for avr_hvpp_responder. Read results are
//                predicted from a bench-side model of flash, fuses and
//                signature, queued when a read is driven and compared when the
//                registered read data is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avr_hvpp_responder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       xtal, xa0, xa1_bs2, pagel_bs1, wr_n, oe_n;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       data_oe;
    logic       rdy;

    int total = 0;
    int bad   = 0;

    logic [7:0]  exp_q [$];
    logic [15:0] mdl_mem [64];
    logic [7:0]  mdl_fuse_lo, mdl_fuse_hi;
    logic [5:0]  mdl_addr;
    logic [7:0]  sig_tbl [4];
    int          lows;

    always #5 clk = ~clk;

    avr_hvpp_responder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .xtal      (xtal),
        .xa0       (xa0),
        .xa1_bs2   (xa1_bs2),
        .pagel_bs1 (pagel_bs1),
        .wr_n      (wr_n),
        .oe_n      (oe_n),
        .data_in   (data_in),
        .data_out  (data_out),
        .data_oe   (data_oe),
        .rdy       (rdy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic xtal_load(input logic [1:0] xa, input logic bs1, input logic [7:0] d);
        {xa1_bs2, xa0} = xa;
        pagel_bs1      = bs1;
        data_in        = d;
        tick(2);
        xtal = 1'b1;
        tick(4);
        xtal = 1'b0;
        tick(4);
    endtask

    task automatic set_cmd(input logic [7:0] c);
        xtal_load(2'b10, 1'b0, c);
    endtask

    task automatic set_addr(input logic [7:0] a);
        xtal_load(2'b00, 1'b0, a);
        mdl_addr = a[5:0];
    endtask

    // WR pulse; counts the sampled cycles with rdy low over a bounded window
    task automatic wr_measure(input logic bs1, input int budget, output int n_low);
        n_low     = 0;
        pagel_bs1 = bs1;
        wr_n      = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!rdy) n_low++;
            if (i == 4) wr_n = 1'b1;
        end
        tick(1);
    endtask

    task automatic do_read(input string tag, input logic bs1, input logic [7:0] exp);
        exp_q.push_back(exp);
        pagel_bs1 = bs1;
        oe_n      = 1'b0;
        tick(4);
        @(negedge clk);
        chk({tag, "_oe"}, data_oe, 1'b1);
        if (exp_q.size() == 0) chk({tag, "_sb_empty"}, 0, 1);
        else                   chk(tag, data_out, exp_q.pop_front());
        oe_n = 1'b1;
        tick(4);
    endtask

    task automatic flash_write(input logic [7:0] a, input logic [15:0] w);
        set_addr(a);
        xtal_load(2'b01, 1'b0, w[7:0]);
        xtal_load(2'b01, 1'b1, w[15:8]);
        set_cmd(8'h10);
        wr_measure(1'b0, 40, lows);
        chk("flash_busy_len", lows, 16);
        mdl_mem[a[5:0]] = w;
    endtask

    initial begin
        sig_tbl   = '{8'h1E, 8'h91, 8'h09, 8'hFF};
        rst_n     = 1'b0;
        xtal      = 1'b0;
        xa0       = 1'b0;
        xa1_bs2   = 1'b0;
        pagel_bs1 = 1'b0;
        wr_n      = 1'b1;
        oe_n      = 1'b1;
        data_in   = 8'h00;
        mdl_fuse_lo = 8'hE1;
        mdl_fuse_hi = 8'hF7;
        mdl_addr    = '0;
        tick(3);
        @(negedge clk);
        chk("rst_rdy", rdy, 1'b1);
        chk("rst_data_oe", data_oe, 1'b0);
        chk("rst_data_out", data_out, 8'hFF);
        rst_n = 1'b1;
        tick(3);

        // Fuse reset values
        set_cmd(8'h04);
        do_read("fuse_lo_init", 1'b0, mdl_fuse_lo);
        do_read("fuse_hi_init", 1'b1, mdl_fuse_hi);

        // XTAL load with OE active must not latch the pins
        oe_n = 1'b0;
        xtal_load(2'b10, 1'b0, 8'h08);
        oe_n = 1'b1;
        tick(3);
        do_read("contention_cmd_kept", 1'b0, mdl_fuse_lo);

        // Fuse write
        xtal_load(2'b01, 1'b0, 8'hA5);
        set_cmd(8'h40);
        wr_measure(1'b0, 40, lows);
        chk("fuse_busy_len", lows, 16);
        mdl_fuse_lo = 8'hA5;
        set_cmd(8'h04);
        do_read("fuse_lo_wr", 1'b0, mdl_fuse_lo);
        do_read("fuse_hi_kept", 1'b1, mdl_fuse_hi);

        // Flash write/read, address wrap and high-byte truncation
        flash_write(8'h05, 16'h1234);
        set_cmd(8'h02);
        set_addr(8'h05);
        do_read("flash5_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        do_read("flash5_hi", 1'b1, mdl_mem[mdl_addr][15:8]);
        set_addr(8'h45);
        do_read("addr_wrap", 1'b0, mdl_mem[mdl_addr][7:0]);
        xtal_load(2'b00, 1'b1, 8'h7F);
        do_read("addr_hi_trunc", 1'b1, mdl_mem[mdl_addr][15:8]);
        flash_write(8'h3F, 16'hBEEF);
        set_cmd(8'h02);
        set_addr(8'h3F);
        do_read("flash63_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        do_read("flash63_hi", 1'b1, mdl_mem[mdl_addr][15:8]);

        // Chip erase
        set_cmd(8'h80);
        wr_measure(1'b0, 100, lows);
        chk("erase_busy_len", lows, 64);
        for (int i = 0; i < 64; i++) mdl_mem[i] = 16'hFFFF;
        set_cmd(8'h02);
        for (int a = 0; a < 64; a++) begin
            set_addr(8'(a));
            do_read("erased_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
            do_read("erased_hi", 1'b1, mdl_mem[mdl_addr][15:8]);
        end
        set_cmd(8'h04);
        do_read("erase_fuse_lo", 1'b0, mdl_fuse_lo);
        do_read("erase_fuse_hi", 1'b1, mdl_fuse_hi);

        // Signature
        set_cmd(8'h08);
        for (int a = 0; a < 4; a++) begin
            set_addr(8'(a));
            do_read("sig", 1'b0, sig_tbl[a]);
        end

        // XTAL, second WR and read while BUSY
        set_addr(8'h0A);
        xtal_load(2'b01, 1'b0, 8'hC3);
        xtal_load(2'b01, 1'b1, 8'h5A);
        set_cmd(8'h10);
        mdl_mem[10] = 16'h5AC3;
        lows = 0;
        wr_n = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (!rdy) lows++;
            case (i)
                1:  begin {xa1_bs2, xa0} = 2'b10; data_in = 8'h80; end
                3:  xtal = 1'b1;
                6:  begin xtal = 1'b0; wr_n = 1'b1; end
                8:  wr_n = 1'b0;
                10: begin oe_n = 1'b0; exp_q.push_back(8'hFF); end
                13: begin
                        chk("busy_read_oe", data_oe, 1'b1);
                        chk("busy_read", data_out, exp_q.pop_front());
                    end
                14: begin oe_n = 1'b1; wr_n = 1'b1; end
                default: ;
            endcase
        end
        tick(1);
        chk("busy_ignore_len", lows, 16);
        // Command still WRITE_FLASH: another WR gives a 16-cycle write, not an erase
        wr_measure(1'b0, 100, lows);
        chk("busy_cmd_kept", lows, 16);
        set_cmd(8'h02);
        set_addr(8'h0A);
        do_read("busy_write_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        do_read("busy_write_hi", 1'b1, mdl_mem[mdl_addr][15:8]);

        // Reset during erase
        flash_write(8'h03, 16'hA1B2);
        flash_write(8'h32, 16'hC3D4);
        set_cmd(8'h80);
        wr_n = 1'b0;
        tick(20);
        @(negedge clk);
        chk("erase_running", rdy, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("abort_rdy", rdy, 1'b1);
        wr_n = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(3);
        // Roughly 17 words are erased by the abort point
        for (int i = 0; i <= 10; i++) mdl_mem[i] = 16'hFFFF;
        mdl_fuse_lo = 8'hE1;
        mdl_fuse_hi = 8'hF7;
        set_cmd(8'h02);
        set_addr(8'h03);
        do_read("abort_w3_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        do_read("abort_w3_hi", 1'b1, mdl_mem[mdl_addr][15:8]);
        set_addr(8'h0A);
        do_read("abort_w10_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        set_addr(8'h32);
        do_read("abort_w50_lo", 1'b0, mdl_mem[mdl_addr][7:0]);
        do_read("abort_w50_hi", 1'b1, mdl_mem[mdl_addr][15:8]);
        set_cmd(8'h04);
        do_read("abort_fuse_lo", 1'b0, mdl_fuse_lo);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_avr_hvpp_responder
`default_nettype wire
